// File: rtl/decode.sv
// MIPS ID stage: register file, main control, sign extension and the ID/EX register.
// Define REGFILE_BYPASS_EN for write-through of a same-edge WB write into the rs/rt read data.
module decode #(
  parameter int          REG_COUNT = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_npc,
  input  logic        id_flush,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_write_data,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_sign_ext,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] r_regs [REG_COUNT];

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sign_ext;
  logic        w_wr_en;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [3:0]  w_ex;
  logic [2:0]  w_m;
  logic [1:0]  w_wb;

  assign w_opcode   = if_id_instr[31:26];
  assign w_rs       = if_id_instr[25:21];
  assign w_rt       = if_id_instr[20:16];
  assign w_rd       = if_id_instr[15:11];
  assign w_imm      = if_id_instr[15:0];
  assign w_sign_ext = {{16{w_imm[15]}}, w_imm};
  assign w_wr_en    = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

`ifdef REGFILE_BYPASS_EN
  assign w_rs_data = (w_rs == 5'd0) ? 32'h0 :
                     (w_wr_en && (mem_wb_write_reg == w_rs)) ? mem_wb_write_data : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'h0 :
                     (w_wr_en && (mem_wb_write_reg == w_rt)) ? mem_wb_write_data : r_regs[w_rt];
`else
  assign w_rs_data = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];
`endif

  // Flush and unknown opcodes both produce an all-zero control bubble.
  always_comb begin
    w_ex = 4'b0000;
    w_m  = 3'b000;
    w_wb = 2'b00;
    if (!id_flush) begin
      case (w_opcode)
        OP_RTYPE: begin w_ex = 4'b1100; w_m = 3'b000; w_wb = 2'b10; end
        OP_LW:    begin w_ex = 4'b0001; w_m = 3'b010; w_wb = 2'b11; end
        OP_SW:    begin w_ex = 4'b0001; w_m = 3'b001; w_wb = 2'b00; end
        OP_BEQ:   begin w_ex = 4'b0010; w_m = 3'b100; w_wb = 2'b00; end
        default:  begin w_ex = 4'b0000; w_m = 3'b000; w_wb = 2'b00; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 32'h0;
    end else if (w_wr_en) begin
      r_regs[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_npc      <= RESET_PC;
      id_ex_rs_data  <= 32'h0;
      id_ex_rt_data  <= 32'h0;
      id_ex_sign_ext <= 32'h0;
      id_ex_rt       <= 5'd0;
      id_ex_rd       <= 5'd0;
      id_ex_wb       <= 2'b00;
      id_ex_m        <= 3'b000;
      id_ex_ex       <= 4'b0000;
    end else begin
      id_ex_npc      <= if_id_npc;
      id_ex_rs_data  <= w_rs_data;
      id_ex_rt_data  <= w_rt_data;
      id_ex_sign_ext <= w_sign_ext;
      id_ex_rt       <= w_rt;
      id_ex_rd       <= w_rd;
      id_ex_wb       <= w_wb;
      id_ex_m        <= w_m;
      id_ex_ex       <= w_ex;
    end
  end

endmodule
